// File: rtl/sat_adder_pkg.sv
// ---------------------------------------------------------------------------
// sat_adder_pkg
// Shared constant helpers for the saturating adder tree.
//   satMax(width) : largest two's complement value of the given width
//   satMin(width) : smallest two's complement value of the given width
//   clog2(value)  : ceiling log2, used to size the tree depth
// No ports; imported by sat_add and sat_adder_tree.
// ---------------------------------------------------------------------------
package sat_adder_pkg;

   // Largest representable value, returned wide so callers can size-cast it
   function automatic longint satMax(input int width);
      return (longint'(1) <<< (width - 1)) - longint'(1);
   endfunction

   // Most negative representable value, returned wide for the same reason
   function automatic longint satMin(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

   // Ceiling log2 evaluated at elaboration time
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((longint'(1) <<< r) < longint'(value)) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// Combinational two-operand saturating adder for signed two's complement.
// Ports:
//   a, b : DWIDTH-bit signed operands
//   s    : DWIDTH-bit signed sum, clamped to MAX/MIN on overflow
//   sat  : 1 when the sum was clamped
// ---------------------------------------------------------------------------
module sat_add
   import sat_adder_pkg::*;
#(
   parameter int DWIDTH = 16
) (
   input  logic [DWIDTH-1:0] a,
   input  logic [DWIDTH-1:0] b,
   output logic [DWIDTH-1:0] s,
   output logic              sat
);

   localparam logic [DWIDTH-1:0] MAX_VAL = DWIDTH'(satMax(DWIDTH));
   localparam logic [DWIDTH-1:0] MIN_VAL = DWIDTH'(satMin(DWIDTH));

   logic [DWIDTH:0] wideSum;

   // One guard bit is enough to hold the exact sum of two DWIDTH operands
   assign wideSum = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};

   // Top two bits differing means the true sum left the DWIDTH range; the
   // guard bit then carries the true sign and selects which rail to clamp to
   always_comb begin
      s   = wideSum[DWIDTH-1:0];
      sat = 1'b0;
      if (wideSum[DWIDTH] != wideSum[DWIDTH-1]) begin
         sat = 1'b1;
         s   = wideSum[DWIDTH] ? MIN_VAL : MAX_VAL;
      end
   end

endmodule

// File: rtl/sat_adder_tree.sv
// ---------------------------------------------------------------------------
// sat_adder_tree
// Pipelined saturating NUM_IN-input adder tree followed by an optional
// accumulate stage. Latency from in_valid to out_valid is log2(NUM_IN)+1.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : operand vector valid (no backpressure)
//   in_last    : closes an accumulation group (only meaningful with in_acc)
//   in_acc     : 0 = pass-through beat, 1 = accumulate beat
//   din        : NUM_IN signed operands, operand k at [k*DWIDTH +: DWIDTH]
//   out_valid  : one-cycle pulse marking a new dout/ovf
//   dout       : signed saturated result, held between pulses
//   ovf        : some stage clamped while producing this result
// ---------------------------------------------------------------------------
module sat_adder_tree
   import sat_adder_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int NUM_IN = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     in_last,
   input  logic                     in_acc,
   input  logic [NUM_IN*DWIDTH-1:0] din,
   output logic                     out_valid,
   output logic [DWIDTH-1:0]        dout,
   output logic                     ovf
);

   localparam int L = clog2(NUM_IN);

   // Tree nodes use heap numbering: node i has children 2i and 2i+1, node 1
   // is the root, and indices NUM_IN..2*NUM_IN-1 are the raw operands. This
   // reproduces the fixed 2k/2k+1 pairing at every stage.
   logic [DWIDTH-1:0] nodeVal [2:2*NUM_IN-1];
   logic [DWIDTH-1:0] node_d  [1:NUM_IN-1];
   logic [DWIDTH-1:0] node_q  [1:NUM_IN-1];
   logic [NUM_IN-1:1] nodeSat;

   logic [L:1] vld_d,  vld_q;
   logic [L:1] last_d, last_q;
   logic [L:1] mode_d, mode_q;
   logic [L:1] sat_d,  sat_q;

   logic [DWIDTH-1:0] accum_d, accum_q;
   logic [DWIDTH-1:0] accBase;
   logic [DWIDTH-1:0] accSum;
   logic              accSat;
   logic              first_d, first_q;
   logic              sticky_d, sticky_q;
   logic              groupOvf;
   logic              outValid_d, outValid_q;
   logic [DWIDTH-1:0] dout_d, dout_q;
   logic              ovf_d, ovf_q;

   // Child view of the tree: registered internal nodes plus the live operands
   for (genvar i = 2; i < NUM_IN; i++) begin : gInner
      assign nodeVal[i] = node_q[i];
   end

   for (genvar k = 0; k < NUM_IN; k++) begin : gLeaf
      assign nodeVal[NUM_IN + k] = din[k*DWIDTH +: DWIDTH];
   end

   // Stage st holds NUM_IN>>st nodes; each node saturating-adds its two children
   for (genvar st = 1; st <= L; st++) begin : gStage
      for (genvar n = 0; n < (NUM_IN >> st); n++) begin : gNode
         localparam int IDX = (NUM_IN >> st) + n;
         sat_add #(.DWIDTH(DWIDTH)) uAdd (
            .a   (nodeVal[2*IDX]),
            .b   (nodeVal[2*IDX + 1]),
            .s   (node_d[IDX]),
            .sat (nodeSat[IDX])
         );
      end
   end

   // Sideband shift: valid/last/mode follow the data one stage per cycle, and
   // the sat flag of each stage ORs every clamp in that stage into the flag
   // inherited from the previous one
   always_comb begin
      vld_d  = '0;
      last_d = '0;
      mode_d = '0;
      sat_d  = '0;
      vld_d[1]  = in_valid;
      last_d[1] = in_last;
      mode_d[1] = in_acc;
      for (int st = 2; st <= L; st++) begin
         vld_d[st]  = vld_q[st-1];
         last_d[st] = last_q[st-1];
         mode_d[st] = mode_q[st-1];
         sat_d[st]  = sat_q[st-1];
      end
      for (int st = 1; st <= L; st++) begin
         for (int i = (NUM_IN >> st); i < (NUM_IN >> (st - 1)); i++) begin
            sat_d[st] = sat_d[st] | nodeSat[i];
         end
      end
   end

   // Tree data needs no reset: stale values are never used without a valid
   always_ff @(posedge clk) begin
      node_q <= node_d;
   end

   // Start of a group adds into zero and ignores whatever sticky flag is left
   assign accBase  = first_q ? '0 : accum_q;
   assign groupOvf = (sticky_q & ~first_q) | sat_q[L] | accSat;

   sat_add #(.DWIDTH(DWIDTH)) uAcc (
      .a   (accBase),
      .b   (node_q[1]),
      .s   (accSum),
      .sat (accSat)
   );

   // Accumulator: a pass-through or last beat emits and reopens the group,
   // any other accumulate beat folds in silently; bubbles change nothing
   always_comb begin
      accum_d    = accum_q;
      first_d    = first_q;
      sticky_d   = sticky_q;
      outValid_d = 1'b0;
      dout_d     = dout_q;
      ovf_d      = ovf_q;
      if (vld_q[L]) begin
         if (!mode_q[L] || last_q[L]) begin
            outValid_d = 1'b1;
            dout_d     = accSum;
            ovf_d      = groupOvf;
            first_d    = 1'b1;
            accum_d    = '0;
            sticky_d   = 1'b0;
         end else begin
            accum_d  = accSum;
            sticky_d = groupOvf;
            first_d  = 1'b0;
         end
      end
   end

   // Control and output registers; reset drops every in-flight beat and any
   // partially accumulated group without producing a pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q      <= '0;
         last_q     <= '0;
         mode_q     <= '0;
         sat_q      <= '0;
         accum_q    <= '0;
         first_q    <= 1'b1;
         sticky_q   <= 1'b0;
         outValid_q <= 1'b0;
         dout_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         vld_q      <= vld_d;
         last_q     <= last_d;
         mode_q     <= mode_d;
         sat_q      <= sat_d;
         accum_q    <= accum_d;
         first_q    <= first_d;
         sticky_q   <= sticky_d;
         outValid_q <= outValid_d;
         dout_q     <= dout_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_valid = outValid_q;
   assign dout      = dout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sat_adder_tree.sv
// ---------------------------------------------------------------------------
// tb_sat_adder_tree
// Directed bench for sat_adder_tree at DWIDTH=16, NUM_IN=4 (three-cycle
// latency, i.e. the result register loads two edges after the beat's edge).
// ---------------------------------------------------------------------------
module tb_sat_adder_tree;

   localparam int DW  = 16;
   localparam int NI  = 4;
   localparam int LAT = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_last;
   logic             in_acc;
   logic [NI*DW-1:0] din;
   logic             out_valid;
   logic [DW-1:0]    dout;
   logic             ovf;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int            edgeNum;
      logic [DW-1:0] d;
      logic          o;
   } pulse_t;

   pulse_t pulses [$];
   pulse_t expq   [$];

   sat_adder_tree #(.DWIDTH(DW), .NUM_IN(NI)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_acc    (in_acc),
      .din       (din),
      .out_valid (out_valid),
      .dout      (dout),
      .ovf       (ovf)
   );

   // Free-running clock and an edge counter used to time every beat and pulse
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Collect every output pulse on the falling edge, tagged with its edge
   always @(negedge clk) begin
      if (out_valid === 1'b1) pulses.push_back('{cyc, dout, ovf});
   end

   // Single point of comparison: counts it and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Present one input cycle; returns the edge number that sampled it
   task automatic applyStimulus(input logic v, input logic acc, input logic last,
                                input logic [DW-1:0] o0, input logic [DW-1:0] o1,
                                input logic [DW-1:0] o2, input logic [DW-1:0] o3,
                                output int edgeNum);
      in_valid = v;
      in_acc   = acc;
      in_last  = last;
      din      = {o3, o2, o1, o0};
      @(posedge clk);
      #1;
      edgeNum  = cyc;
      in_valid = 1'b0;
      in_acc   = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drain the pipe and expect exactly one pulse with the given contents
   task automatic expectOne(input string tag, input logic [DW-1:0] expD,
                            input logic expO, input int expEdge);
      idle(LAT + 3);
      checkOutput({tag, ".count"}, 32'(pulses.size()), 32'd1);
      if (pulses.size() > 0) begin
         checkOutput({tag, ".dout"}, 32'(pulses[0].d), 32'(expD));
         checkOutput({tag, ".ovf"},  32'(pulses[0].o), 32'(expO));
         checkOutput({tag, ".edge"}, 32'(pulses[0].edgeNum), 32'(expEdge));
      end
      checkOutput({tag, ".hold"}, 32'(dout), 32'(expD));
      pulses.delete();
   endtask

   // Reference saturating add using plain integer range checks
   function automatic logic [DW-1:0] refSat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            output logic s);
      int r;
      r = int'($signed(a)) + int'($signed(b));
      s = 1'b0;
      if (r > 32767) begin
         s = 1'b1;
         return 16'h7FFF;
      end
      if (r < -32768) begin
         s = 1'b1;
         return 16'h8000;
      end
      return r[DW-1:0];
   endfunction

   // Directed cases, then a short randomised stream against the reference
   initial begin
      int e;
      int e1;
      logic [DW-1:0] ops [8][4];
      bit accPat  [8] = '{1, 1, 0, 1, 0, 1, 1, 0};
      bit lastPat [8] = '{0, 1, 0, 0, 0, 0, 1, 0};
      logic [DW-1:0] mAcc;
      logic          mFirst;
      logic          mSticky;
      logic [DW-1:0] s0, s1, t, sum;
      logic          f0, f1, f2, fa, fTot;
      int            n;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_acc   = 1'b0;
      in_last  = 1'b0;
      din      = '0;
      idle(3);
      rst = 1'b0;
      checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset.dout",      32'(dout),      32'd0);
      checkOutput("reset.ovf",       32'(ovf),       32'd0);

      applyStimulus(1, 0, 0, 16'h0800, 16'h0800, 16'h0800, 16'h0800, e);
      expectOne("pass", 16'h2000, 1'b0, e + LAT);

      applyStimulus(1, 0, 0, 16'h7000, 16'h7000, 16'h7000, 16'h7000, e);
      expectOne("clampPos", 16'h7FFF, 1'b1, e + LAT);

      applyStimulus(1, 0, 0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, e);
      expectOne("clampNeg", 16'h8000, 1'b1, e + LAT);

      applyStimulus(1, 0, 0, 16'h7000, 16'h7000, 16'h9000, 16'h9000, e);
      expectOne("order", 16'hFFFF, 1'b1, e + LAT);

      applyStimulus(1, 1, 0, 16'h0200, 16'h0200, 16'h0200, 16'h0200, e);
      applyStimulus(1, 1, 0, 16'h0200, 16'h0200, 16'h0200, 16'h0200, e);
      idle(1);
      applyStimulus(1, 1, 1, 16'h0200, 16'h0200, 16'h0200, 16'h0200, e);
      expectOne("accBubble", 16'h1800, 1'b0, e + LAT);

      applyStimulus(1, 1, 0, 16'h2000, 16'h2000, 16'h2000, 16'h2000, e);
      applyStimulus(1, 1, 0, 16'h2000, 16'h2000, 16'h2000, 16'h2000, e);
      idle(1);
      applyStimulus(1, 1, 1, 16'h2000, 16'h2000, 16'h2000, 16'h2000, e);
      expectOne("accSat", 16'h7FFF, 1'b1, e + LAT);

      applyStimulus(1, 1, 0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, e);
      applyStimulus(1, 1, 0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, e);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      checkOutput("midReset.out_valid", 32'(out_valid), 32'd0);
      checkOutput("midReset.dout",      32'(dout),      32'd0);
      checkOutput("midReset.ovf",       32'(ovf),       32'd0);
      applyStimulus(1, 1, 1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, e);
      expectOne("midReset", 16'h0400, 1'b0, e + LAT);

      mAcc    = '0;
      mFirst  = 1'b1;
      mSticky = 1'b0;
      for (int b = 0; b < 8; b++) begin
         for (int k = 0; k < 4; k++) begin
            if (b % 2 == 0) ops[b][k] = 16'($urandom());
            else            ops[b][k] = 16'($urandom_range(0, 4095)) - 16'd2048;
         end
         applyStimulus(1, accPat[b], lastPat[b], ops[b][0], ops[b][1], ops[b][2], ops[b][3], e1);
         s0   = refSat(ops[b][0], ops[b][1], f0);
         s1   = refSat(ops[b][2], ops[b][3], f1);
         t    = refSat(s0, s1, f2);
         sum  = refSat(mFirst ? 16'h0000 : mAcc, t, fa);
         fTot = (mFirst ? 1'b0 : mSticky) | f0 | f1 | f2 | fa;
         if (!accPat[b] || lastPat[b]) begin
            expq.push_back('{e1 + LAT, sum, fTot});
            mFirst  = 1'b1;
            mAcc    = '0;
            mSticky = 1'b0;
         end else begin
            mAcc    = sum;
            mSticky = fTot;
            mFirst  = 1'b0;
         end
      end
      idle(LAT + 3);
      checkOutput("stream.count", 32'(pulses.size()), 32'(expq.size()));
      n = (pulses.size() < expq.size()) ? pulses.size() : expq.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("stream%0d.dout", i), 32'(pulses[i].d),       32'(expq[i].d));
         checkOutput($sformatf("stream%0d.ovf",  i), 32'(pulses[i].o),       32'(expq[i].o));
         checkOutput($sformatf("stream%0d.edge", i), 32'(pulses[i].edgeNum), 32'(expq[i].edgeNum));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
